prog_timer: RTL

PROG_TIMER -- requirements
Module: prog_timer

---
 rtl/prog_timer_pkg.sv | 44 ++++
 rtl/prog_timer_tick_gen.sv | 41 ++++
 rtl/prog_timer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/prog_timer_pkg.sv
// -----------------------------------------------------------------------------
// prog_timer_pkg
// Shared timer definitions used by every timer block: FSM state encodings,
// run-mode constants, default prescale rate and the command priority decode.
// -----------------------------------------------------------------------------
package prog_timer_pkg;

    // One system cycle is 1/240 s unless a block overrides it.
    localparam int TICKS_PER_SEC_DEF = 240;
    localparam int SEC_W_DEF         = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } timer_state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_START = 2'd2,
        CMD_PAUSE = 2'd3
    } timer_cmd_e;

    // Resolve simultaneous commands: stop beats start beats pause.
    // start_ok must already exclude a start with a zero period.
    function automatic timer_cmd_e decode_cmd(input logic stop,
                                              input logic start_ok,
                                              input logic pause);
        if (stop) begin
            return CMD_STOP;
        end else if (start_ok) begin
            return CMD_START;
        end else if (pause) begin
            return CMD_PAUSE;
        end else begin
            return CMD_NONE;
        end
    endfunction

endpackage

// File: rtl/prog_timer_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Seconds prescaler: counts 0..TICKS_PER_SEC-1 while enabled and wraps to 0.
// tick is high in the cycle the count sits at its last value while enabled,
// i.e. the cycle whose closing edge completes one second.
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset, clears the count
//   en    in   advance the count this cycle
//   clr   in   clear the count (wins over en)
//   tick  out  last prescale cycle of the current second
// -----------------------------------------------------------------------------
module tick_gen
    import prog_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/prog_timer.sv
// -----------------------------------------------------------------------------
// prog_timer
// Programmable seconds timer, one-shot or periodic, with pause and abort.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | not counting, remaining held at 0
//   RUN   | prescaler advancing, remaining decremented once per second
//   HOLD  | paused, prescaler and remaining frozen
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   load period/mode and run (ignored when period is 0)
//   stop       in   abort to IDLE
//   pause      in   level, freeze counting while high
//   mode       in   0 one-shot, 1 periodic, sampled with start
//   period     in   duration in seconds, sampled with start
//   sec_pulse  out  one-cycle pulse per elapsed second
//   done       out  one-cycle pulse on expiry, coincident with last sec_pulse
//   busy       out  high in RUN or HOLD
//   remaining  out  seconds left in the current period
// -----------------------------------------------------------------------------
module prog_timer
    import prog_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
    parameter int SEC_W         = SEC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [SEC_W-1:0] period,
    output logic             sec_pulse,
    output logic             done,
    output logic             busy,
    output logic [SEC_W-1:0] remaining
);

    timer_state_e     state_q;
    timer_state_e     state_d;
    timer_cmd_e       cmd;
    logic [SEC_W-1:0] rem_q;
    logic [SEC_W-1:0] rem_d;
    logic [SEC_W-1:0] period_q;
    logic             mode_q;

    logic start_ok;
    logic last_sec;
    logic presc_en;
    logic presc_clr;
    logic tick;

    logic sec_pulse_d;
    logic done_d;
    logic busy_d;

    assign start_ok = start && (period != '0);
    assign cmd      = decode_cmd(stop, start_ok, pause);
    assign last_sec = (rem_q == SEC_W'(1));

    // The prescaler advances on every RUN cycle, including the cycle in which
    // pause is first seen, so the frozen span equals the number of cycles
    // pause was sampled high. Stop and start both restart the second.
    assign presc_en  = (state_q == ST_RUN) && (cmd != CMD_STOP) && (cmd != CMD_START);
    assign presc_clr = (cmd == CMD_STOP) || (cmd == CMD_START);

    tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    // State and timer data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            period_q <= '0;
            mode_q   <= MODE_ONESHOT;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (cmd == CMD_START) begin
                period_q <= period;
                mode_q   <= mode;
            end
        end
    end

    // Next-state and next-remaining logic.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (cmd)
            CMD_STOP: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
            CMD_START: begin
                state_d = ST_RUN;
                rem_d   = period;
            end
            default: begin
                case (state_q)
                    ST_RUN: begin
                        if (tick) begin
                            if (!last_sec) begin
                                rem_d = rem_q - 1'b1;
                            end else if (mode_q == MODE_PERIODIC) begin
                                rem_d = period_q;
                            end else begin
                                rem_d = '0;
                            end
                        end
                        // A one-shot expiry finishes the run even if pause
                        // arrives in the same cycle.
                        if (tick && last_sec && (mode_q == MODE_ONESHOT)) begin
                            state_d = ST_IDLE;
                        end else if (cmd == CMD_PAUSE) begin
                            state_d = ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (cmd != CMD_PAUSE) begin
                            state_d = ST_RUN;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        endcase
    end

    // Next output values; tick is already suppressed by stop and start.
    always_comb begin
        sec_pulse_d = tick;
        done_d      = tick && last_sec;
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_pulse <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sec_pulse <= sec_pulse_d;
            done      <= done_d;
            busy      <= busy_d;
        end
    end

    assign remaining = rem_q;

endmodule
